// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the clock divider bank: board clock figures,
// default channel reset divisors and the effective-divisor mapping.
package clock_divider_pkg;

    localparam int CNT_W_DEFAULT  = 28;
    localparam int NUM_CH_DEFAULT = 4;

    // 100 MHz board clock and the divisors for the standard channel rates
    localparam int SYS_CLK_HZ = 100_000_000;
    localparam int DIV_1HZ    = SYS_CLK_HZ;
    localparam int DIV_2HZ    = SYS_CLK_HZ / 2;
    localparam int DIV_5HZ    = SYS_CLK_HZ / 5;
    localparam int DIV_10KHZ  = SYS_CLK_HZ / 10_000;

    localparam logic [NUM_CH_DEFAULT*CNT_W_DEFAULT-1:0] DIV_RESET_DEFAULT = {
        CNT_W_DEFAULT'(DIV_1HZ),
        CNT_W_DEFAULT'(DIV_2HZ),
        CNT_W_DEFAULT'(DIV_5HZ),
        CNT_W_DEFAULT'(DIV_10KHZ)
    };

    // Divisor arithmetic is done at this width; channel counters must not exceed it.
    localparam int EFF_DIV_W = 32;

    function automatic logic [EFF_DIV_W-1:0] eff_div(input logic [EFF_DIV_W-1:0] div);
        return (div < EFF_DIV_W'(2)) ? EFF_DIV_W'(2) : div;
    endfunction

endpackage

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: counter, active/pending divisor, square-wave compare and
// tick strobe (tick logic only when CLOCK_DIVIDER_BANK_TICK_EN is defined).
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(10_000)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_value_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic [CNT_W-1:0] eff;
    logic             wrap;
    logic             cmp;
    logic             apply;

    // The divisor only changes at a wrap or while stopped, so the old period always completes.
    always_comb begin
        eff    = CNT_W'(eff_div(EFF_DIV_W'(div_q)));
        wrap   = (cnt_q >= eff - CNT_W'(1));
        cmp    = (cnt_q >= (eff >> 1));
        apply  = pend_q & (~enable_i | wrap);
        cnt_d  = '0;
        clk_d  = 1'b0;
        if (enable_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            clk_d = cmp;
        end
        div_d  = apply ? pdiv_q : div_q;
        pdiv_d = wr_i ? wr_value_i : pdiv_q;
        pend_d = wr_i | (pend_q & ~apply);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            div_q  <= DIV_INIT;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;

`ifdef CLOCK_DIVIDER_BANK_TICK_EN
    logic tick_q, tick_d;

    // Rising edge of the compare, registered so it lines up with the first high cycle of clk_o.
    always_comb begin
        tick_d = enable_i & cmp & ~clk_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock/tick divider bank with write decode.
// Tick strobes are generated only when CLOCK_DIVIDER_BANK_TICK_EN is defined.
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int                        NUM_CH    = NUM_CH_DEFAULT,
    parameter int                        CNT_W     = CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_RESET = DIV_RESET_DEFAULT,
    localparam int                       CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] ch_enable_i,
    input  logic              div_wr_i,
    input  logic [CH_W-1:0]   div_ch_i,
    input  logic [CNT_W-1:0]  div_value_i,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0] wr_sel;

    // Addresses with no matching channel select nothing, so such writes are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = div_wr_i && (div_ch_i == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_RESET[g*CNT_W +: CNT_W])
        ) u_ch (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .enable_i   (ch_enable_i[g]),
            .wr_i       (wr_sel[g]),
            .wr_value_i (div_value_i),
            .pending_o  (pending_o[g]),
            .clk_o      (clk_o[g]),
            .tick_o     (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank with three channels and small divisors.
module tb_clock_divider_bank;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 28;
    localparam int CH_W   = 2;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_RESET = {28'd6, 28'd5, 28'd4};

`ifdef CLOCK_DIVIDER_BANK_TICK_EN
    localparam logic TK = 1'b1;
`else
    localparam logic TK = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_i;
    logic [NUM_CH-1:0] ch_enable_i;
    logic              div_wr_i;
    logic [CH_W-1:0]   div_ch_i;
    logic [CNT_W-1:0]  div_value_i;
    logic [NUM_CH-1:0] pending_o;
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] tick_o;

    int checks = 0;
    int errors = 0;
    int guard;

    clock_divider_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset_i),
        .ch_enable_i (ch_enable_i),
        .div_wr_i    (div_wr_i),
        .div_ch_i    (div_ch_i),
        .div_value_i (div_value_i),
        .pending_o   (pending_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o)
    );

    always #5 clock = ~clock;

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic wr,
                                 input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val);
        ch_enable_i = en;
        div_wr_i    = wr;
        div_ch_i    = ch;
        div_value_i = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Syncs to the next rising edge of clk_o[ch], then measures one full high+low period.
    task automatic measurePeriod(input int ch, input int exp_high, input int exp_low, input string tag);
        int   high_cnt, low_cnt, stray_ticks, lim;
        logic prev_clk;
        lim      = 0;
        prev_clk = clk_o[ch];
        stepCycle();
        while (!(prev_clk == 1'b0 && clk_o[ch] == 1'b1) && lim < 200) begin
            prev_clk = clk_o[ch];
            stepCycle();
            lim++;
        end
        checkOutput({tag, "_sync"}, 32'(lim < 200), 32'd1);
        checkOutput({tag, "_tick_first"}, 32'(tick_o[ch]), 32'(TK));
        high_cnt    = 0;
        low_cnt     = 0;
        stray_ticks = 0;
        lim         = 0;
        while (clk_o[ch] === 1'b1 && lim < 200) begin
            if (high_cnt > 0 && tick_o[ch] !== 1'b0) stray_ticks++;
            high_cnt++;
            stepCycle();
            lim++;
        end
        while (clk_o[ch] === 1'b0 && lim < 400) begin
            if (tick_o[ch] !== 1'b0) stray_ticks++;
            low_cnt++;
            stepCycle();
            lim++;
        end
        checkOutput({tag, "_high"}, 32'(high_cnt), 32'(exp_high));
        checkOutput({tag, "_low"}, 32'(low_cnt), 32'(exp_low));
        checkOutput({tag, "_stray_ticks"}, 32'(stray_ticks), 32'd0);
        checkOutput({tag, "_tick_next"}, 32'(tick_o[ch]), 32'(TK));
    endtask

    initial begin
        reset_i = 1'b1;
        applyStimulus(3'b000, 1'b0, 2'd0, 28'd0);

        // Reset state
        repeat (3) stepCycle();
        checkOutput("reset_clk", 32'(clk_o), 32'd0);
        checkOutput("reset_tick", 32'(tick_o), 32'd0);
        checkOutput("reset_pending", 32'(pending_o), 32'd0);

        // Enable ch0 (div 4) and ch1 (div 5): first tick on the third cycle
        reset_i = 1'b0;
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        stepCycle();
        checkOutput("start_clk_c1", 32'(clk_o), 32'd0);
        stepCycle();
        checkOutput("start_clk_c2", 32'(clk_o), 32'd0);
        checkOutput("start_tick_c2", 32'(tick_o), 32'd0);
        stepCycle();
        checkOutput("start_clk_c3", 32'(clk_o), 32'b011);
        checkOutput("start_tick_c3", 32'(tick_o), 32'({1'b0, TK, TK}));
        measurePeriod(1, 3, 2, "ch1_div5");
        measurePeriod(0, 2, 2, "ch0_div4");

        // ch0 now at cnt=3; write 6 when cnt=1
        stepCycle();
        stepCycle();
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd6);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("wr6_pending_a", 32'(pending_o[0]), 32'd1);
        checkOutput("wr6_clk_a", 32'(clk_o[0]), 32'd0);
        stepCycle();
        checkOutput("wr6_pending_b", 32'(pending_o[0]), 32'd1);
        checkOutput("wr6_clk_b", 32'(clk_o[0]), 32'd1);
        stepCycle();
        checkOutput("wr6_pending_c", 32'(pending_o[0]), 32'd0);
        checkOutput("wr6_clk_c", 32'(clk_o[0]), 32'd1);
        stepCycle();
        checkOutput("wr6_clk_d", 32'(clk_o[0]), 32'd0);
        measurePeriod(0, 3, 3, "ch0_div6");

        // ch0 at cnt=4 of div 6: two writes (8, 10) then a write of 12 on the wrap cycle
        stepCycle();
        stepCycle();
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd8);
        stepCycle();
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd10);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("last_wins_pending", 32'(pending_o[0]), 32'd1);
        repeat (3) stepCycle();
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd12);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("wrap_wr_pending_held", 32'(pending_o[0]), 32'd1);
        measurePeriod(0, 5, 6, "ch0_div10_to_12");
        checkOutput("wrap_wr_applied", 32'(pending_o[0]), 32'd0);
        measurePeriod(0, 6, 6, "ch0_div12");

        // Divisor 0 behaves as 2
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd0);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("div0_pending", 32'(pending_o[0]), 32'd1);
        guard = 0;
        while (pending_o[0] === 1'b1 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkOutput("div0_applied", 32'(pending_o[0]), 32'd0);
        measurePeriod(0, 1, 1, "ch0_div0");

        // Divisor 1 behaves as 2
        applyStimulus(3'b011, 1'b1, 2'd0, 28'd1);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("div1_pending", 32'(pending_o[0]), 32'd1);
        guard = 0;
        while (pending_o[0] === 1'b1 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkOutput("div1_applied", 32'(pending_o[0]), 32'd0);
        measurePeriod(0, 1, 1, "ch0_div1");

        // Out-of-range channel write is ignored
        applyStimulus(3'b011, 1'b1, 2'd3, 28'd7);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("oor_pending", 32'(pending_o), 32'd0);
        measurePeriod(0, 1, 1, "oor_ch0");
        measurePeriod(1, 3, 2, "oor_ch1");
        checkOutput("oor_ch2_clk", 32'(clk_o[2]), 32'd0);

        // ch1 at cnt=3 (high phase): write 8, then disable while still high
        applyStimulus(3'b011, 1'b1, 2'd1, 28'd8);
        stepCycle();
        applyStimulus(3'b001, 1'b0, 2'd0, 28'd0);
        checkOutput("dis_pending_before", 32'(pending_o[1]), 32'd1);
        checkOutput("dis_clk_before", 32'(clk_o[1]), 32'd1);
        stepCycle();
        checkOutput("dis_clk_after", 32'(clk_o[1]), 32'd0);
        checkOutput("dis_tick_after", 32'(tick_o[1]), 32'd0);
        checkOutput("dis_pending_applied", 32'(pending_o[1]), 32'd0);
        stepCycle();
        checkOutput("dis_clk_hold", 32'(clk_o[1]), 32'd0);

        // Re-enable ch1 with div 8: first tick after floor(8/2)+1 = 5 cycles
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkOutput($sformatf("reen_clk_c%0d", i), 32'(clk_o[1]), 32'd0);
            checkOutput($sformatf("reen_tick_c%0d", i), 32'(tick_o[1]), 32'd0);
        end
        stepCycle();
        checkOutput("reen_clk_c5", 32'(clk_o[1]), 32'd1);
        checkOutput("reen_tick_c5", 32'(tick_o[1]), 32'(TK));
        measurePeriod(1, 4, 4, "ch1_div8");

        // Reset with a write pending on ch1
        applyStimulus(3'b011, 1'b1, 2'd1, 28'd9);
        stepCycle();
        applyStimulus(3'b011, 1'b0, 2'd0, 28'd0);
        checkOutput("rst_pending_before", 32'(pending_o[1]), 32'd1);
        reset_i = 1'b1;
        stepCycle();
        checkOutput("rst_clk", 32'(clk_o), 32'd0);
        checkOutput("rst_tick", 32'(tick_o), 32'd0);
        checkOutput("rst_pending", 32'(pending_o), 32'd0);
        reset_i = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_restart_c2", 32'(clk_o), 32'd0);
        stepCycle();
        checkOutput("rst_restart_clk_c3", 32'(clk_o), 32'b011);
        checkOutput("rst_restart_tick_c3", 32'(tick_o), 32'({1'b0, TK, TK}));
        measurePeriod(1, 3, 2, "rst_ch1_div5");
        measurePeriod(0, 2, 2, "rst_ch0_div4");
        checkOutput("rst_pending_final", 32'(pending_o), 32'd0);
        checkOutput("ch2_tick_final", 32'(tick_o[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
